window_sequencer: RTL and testbench

WINDOW_SEQUENCER -- requirements
Module: window_sequencer

---
 rtl/window_sequencer.sv | 138 +++++++++++++
 tb/tb_window_sequencer.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/window_sequencer.sv
// Raster-order sequencer for a KernelWidth x KernelWidth sliding window.
// Paces upstream pixels into the window/line buffers and flags complete kernels downstream.
module window_sequencer #(
  parameter int KernelWidth = 3,
  parameter int ImageWidth  = 640,
  parameter int ImageHeight = 480
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           start_i,
  input  logic                           valid_i,
  output logic                           ready_o,
  output logic                           shift_o,
  output logic                           valid_o,
  input  logic                           ready_i,
  output logic [$clog2(ImageWidth)-1:0]  col_o,
  output logic [$clog2(ImageHeight)-1:0] row_o,
  output logic                           busy_o,
  output logic                           frame_done_o
);

  // state  | meaning
  // IDLE   | waiting for start_i, upstream stalled
  // ACTIVE | accepting pixels, raising valid_o once a kernel is complete
  // DRAIN  | last pixel taken, waiting for the final kernel to be consumed
  // DONE   | one-cycle frame completion pulse

  localparam int ColW = $clog2(ImageWidth);
  localparam int RowW = $clog2(ImageHeight);

  localparam logic [ColW-1:0] ColLast  = ColW'(ImageWidth - 1);
  localparam logic [RowW-1:0] RowLast  = RowW'(ImageHeight - 1);
  localparam logic [ColW-1:0] ColPrime = ColW'(KernelWidth - 1);
  localparam logic [RowW-1:0] RowPrime = RowW'(KernelWidth - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACTIVE,
    ST_DRAIN,
    ST_DONE
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ColW-1:0]   r_col;
  logic [ColW-1:0]   w_col_nxt;
  logic [RowW-1:0]   r_row;
  logic [RowW-1:0]   w_row_nxt;
  logic              r_valid;
  logic              w_valid_nxt;

  logic              w_in_fire;
  logic              w_out_fire;
  logic              w_qualify;
  logic              w_col_last;
  logic              w_row_last;

  // Upstream is held off whenever an unconsumed kernel would be overwritten.
  assign ready_o    = (r_state == ST_ACTIVE) && (!r_valid || ready_i);
  assign w_in_fire  = valid_i && ready_o;
  assign w_out_fire = r_valid && ready_i;
  assign w_col_last = (r_col == ColLast);
  assign w_row_last = (r_row == RowLast);
  assign w_qualify  = w_in_fire && (r_row >= RowPrime) && (r_col >= ColPrime);

  always_comb begin
    w_state_nxt = r_state;
    w_col_nxt   = r_col;
    w_row_nxt   = r_row;
    unique case (r_state)
      ST_IDLE: begin
        if (start_i) begin
          w_state_nxt = ST_ACTIVE;
          w_col_nxt   = '0;
          w_row_nxt   = '0;
        end
      end
      ST_ACTIVE: begin
        if (w_in_fire) begin
          if (w_col_last) begin
            w_col_nxt = '0;
            if (w_row_last) begin
              w_row_nxt   = '0;
              w_state_nxt = ST_DRAIN;
            end else begin
              w_row_nxt = r_row + RowW'(1);
            end
          end else begin
            w_col_nxt = r_col + ColW'(1);
          end
        end
      end
      ST_DRAIN: begin
        if (!r_valid || ready_i) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // A fresh kernel arriving on the consuming edge keeps valid_o asserted.
  always_comb begin
    w_valid_nxt = r_valid;
    if (w_qualify) begin
      w_valid_nxt = 1'b1;
    end else if (w_out_fire) begin
      w_valid_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= ST_IDLE;
      r_col   <= '0;
      r_row   <= '0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_col   <= w_col_nxt;
      r_row   <= w_row_nxt;
      r_valid <= w_valid_nxt;
    end
  end

  assign shift_o      = w_in_fire;
  assign valid_o      = r_valid;
  assign col_o        = r_col;
  assign row_o        = r_row;
  assign busy_o       = (r_state != ST_IDLE);
  assign frame_done_o = (r_state == ST_DONE);

endmodule

// File: tb/tb_window_sequencer.sv
// Directed bench for window_sequencer on a 4x4 image with a 3x3 kernel.
// A small reference model supplies per-cycle expectations; scenarios add fixed-count checks.
module tb_window_sequencer;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       start_i;
  logic       valid_i;
  logic       ready_o;
  logic       shift_o;
  logic       valid_o;
  logic       ready_i;
  logic [1:0] col_o;
  logic [1:0] row_o;
  logic       busy_o;
  logic       frame_done_o;

  window_sequencer #(
    .KernelWidth(3),
    .ImageWidth (4),
    .ImageHeight(4)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .start_i     (start_i),
    .valid_i     (valid_i),
    .ready_o     (ready_o),
    .shift_o     (shift_o),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .col_o       (col_o),
    .row_o       (row_o),
    .busy_o      (busy_o),
    .frame_done_o(frame_done_o)
  );

  always #5 clk_i = ~clk_i;

  int n_vec  = 0;
  int n_fail = 0;

  // reference model: 0 idle, 1 active, 2 drain, 3 done
  int         m_state;
  logic [1:0] m_col;
  logic [1:0] m_row;
  logic       m_valid;

  logic [8:0] w_obs;
  assign w_obs = {ready_o, shift_o, valid_o, busy_o, frame_done_o, col_o, row_o};

  function automatic logic exp_ready();
    return (m_state == 1) && (!m_valid || ready_i);
  endfunction

  function automatic logic exp_fire();
    return valid_i && exp_ready();
  endfunction

  function automatic logic [8:0] exp_vec();
    return {exp_ready(), exp_fire(), m_valid, m_state != 0, m_state == 3, m_col, m_row};
  endfunction

  task automatic model_reset();
    m_state = 0;
    m_col   = 2'd0;
    m_row   = 2'd0;
    m_valid = 1'b0;
  endtask

  task automatic model_step();
    logic fire;
    logic qual;
    int   ns;
    fire = exp_fire();
    qual = fire && (m_row >= 2) && (m_col >= 2);
    ns   = m_state;
    case (m_state)
      0: if (start_i) begin ns = 1; m_col = 0; m_row = 0; end
      1: if (fire) begin
           if (m_col == 3) begin
             m_col = 0;
             if (m_row == 3) begin m_row = 0; ns = 2; end
             else m_row = m_row + 2'd1;
           end else m_col = m_col + 2'd1;
         end
      2: if (!m_valid || ready_i) ns = 3;
      default: ns = 0;
    endcase
    if (qual) m_valid = 1'b1;
    else if (m_valid && ready_i) m_valid = 1'b0;
    m_state = ns;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0; start_i = 1'b0; valid_i = 1'b1; ready_i = 1'b1;
    model_reset();
    repeat (2) begin
      @(negedge clk_i);
      n_vec++;
      if (w_obs !== 9'b0) begin
        n_fail++;
        $display("FAIL reset_hold: got %b want %b", w_obs, 9'b0);
      end
    end
    rst_ni = 1'b1;
    tick();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_i);
      n_vec++;
      if (w_obs !== 9'b0) begin
        n_fail++;
        $display("FAIL idle_ignores_valid cyc%0d: got %b want %b", c, w_obs, 9'b0);
      end
      tick();
    end
    valid_i = 1'b0;
  endtask

  task automatic test_stream();
    int outs = 0, fd = 0, fires = 0, first = -1;
    bit done = 0;
    start_i = 1'b1; valid_i = 1'b1; ready_i = 1'b1;
    @(negedge clk_i);
    n_vec++;
    if (ready_o !== 1'b0) begin
      n_fail++;
      $display("FAIL stream_idle_ready: got %b want 0", ready_o);
    end
    tick();
    start_i = 1'b0;
    for (int c = 0; c < 60 && !done; c++) begin
      @(negedge clk_i);
      n_vec++;
      if (w_obs !== exp_vec()) begin
        n_fail++;
        $display("FAIL stream cyc%0d: got %b want %b", c, w_obs, exp_vec());
      end
      if (valid_o && ready_i) outs++;
      if (frame_done_o) fd++;
      if (valid_o && first < 0) first = fires;
      if (exp_fire()) fires++;
      tick();
      if (m_state == 0) done = 1;
    end
    n_vec++;
    if (!done || outs != 4 || fd != 1 || first != 11) begin
      n_fail++;
      $display("FAIL stream_totals: got done=%0d outs=%0d done_pulses=%0d first_after=%0d want 1 4 1 11",
               done, outs, fd, first);
    end
  endtask

  task automatic test_backpressure();
    int outs = 0, fd = 0, hold = 0;
    bit done = 0;
    start_i = 1'b1; valid_i = 1'b1; ready_i = 1'b1;
    tick();
    start_i = 1'b0;
    for (int c = 0; c < 80 && !done; c++) begin
      if (valid_o && hold < 5) begin ready_i = 1'b0; hold++; end
      else ready_i = 1'b1;
      @(negedge clk_i);
      n_vec++;
      if (w_obs !== exp_vec()) begin
        n_fail++;
        $display("FAIL backpressure cyc%0d: got %b want %b", c, w_obs, exp_vec());
      end
      if (!ready_i) begin
        n_vec++;
        if ({ready_o, shift_o, valid_o, col_o, row_o} !== {1'b0, 1'b0, 1'b1, 2'd3, 2'd2}) begin
          n_fail++;
          $display("FAIL backpressure_freeze cyc%0d: got r=%b s=%b v=%b col=%0d row=%0d want 0 0 1 3 2",
                   c, ready_o, shift_o, valid_o, col_o, row_o);
        end
      end
      if (valid_o && ready_i) outs++;
      if (frame_done_o) fd++;
      tick();
      if (m_state == 0) done = 1;
    end
    n_vec++;
    if (!done || outs != 4 || fd != 1 || hold != 5) begin
      n_fail++;
      $display("FAIL backpressure_totals: got done=%0d outs=%0d done_pulses=%0d held=%0d want 1 4 1 5",
               done, outs, fd, hold);
    end
    ready_i = 1'b1;
  endtask

  task automatic test_priming();
    int fires = 0, pf = -1, outs = 0;
    bit done = 0;
    start_i = 1'b1; valid_i = 1'b0; ready_i = 1'b1;
    tick();
    start_i = 1'b0;
    for (int c = 0; c < 80 && !done; c++) begin
      valid_i = c[0];
      @(negedge clk_i);
      n_vec++;
      if (w_obs !== exp_vec()) begin
        n_fail++;
        $display("FAIL priming cyc%0d: got %b want %b", c, w_obs, exp_vec());
      end
      if (pf == 8 || pf == 9 || pf == 10) begin
        n_vec++;
        if (valid_o !== (pf == 10)) begin
          n_fail++;
          $display("FAIL priming_pixel%0d: got valid_o=%b want %b", pf, valid_o, pf == 10);
        end
      end
      if (valid_o && ready_i) outs++;
      pf = exp_fire() ? fires : -1;
      if (exp_fire()) fires++;
      tick();
      if (m_state == 0) done = 1;
    end
    n_vec++;
    if (!done || outs != 4) begin
      n_fail++;
      $display("FAIL priming_totals: got done=%0d outs=%0d want 1 4", done, outs);
    end
  endtask

  task automatic test_random();
    int outs = 0, fd = 0;
    bit done = 0;
    start_i = 1'b1; valid_i = 1'b0; ready_i = 1'b0;
    tick();
    start_i = 1'b0;
    for (int c = 0; c < 500 && !done; c++) begin
      valid_i = 1'($urandom_range(0, 1));
      ready_i = 1'($urandom_range(0, 1));
      @(negedge clk_i);
      n_vec++;
      if (w_obs !== exp_vec()) begin
        n_fail++;
        $display("FAIL random cyc%0d: got %b want %b", c, w_obs, exp_vec());
      end
      if (valid_o && ready_i) outs++;
      if (frame_done_o) fd++;
      tick();
      if (m_state == 0) done = 1;
    end
    n_vec++;
    if (!done || outs != 4 || fd != 1) begin
      n_fail++;
      $display("FAIL random_totals: got done=%0d outs=%0d done_pulses=%0d want 1 4 1", done, outs, fd);
    end
    valid_i = 1'b0; ready_i = 1'b1;
  endtask

  task automatic test_reset_midframe();
    int outs = 0, fd = 0;
    bit done = 0;
    start_i = 1'b1; valid_i = 1'b1; ready_i = 1'b1;
    tick();
    start_i = 1'b0;
    repeat (7) tick();
    n_vec++;
    if ({busy_o, col_o, row_o} !== {1'b1, 2'd3, 2'd1}) begin
      n_fail++;
      $display("FAIL midframe_position: got busy=%b col=%0d row=%0d want 1 3 1", busy_o, col_o, row_o);
    end
    #2 rst_ni = 1'b0;
    model_reset();
    #1;
    n_vec++;
    if (w_obs !== 9'b0) begin
      n_fail++;
      $display("FAIL midframe_async_reset: got %b want %b", w_obs, 9'b0);
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
    tick();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk_i);
      n_vec++;
      if (w_obs !== 9'b0) begin
        n_fail++;
        $display("FAIL post_reset_idle cyc%0d: got %b want %b", c, w_obs, 9'b0);
      end
      tick();
    end
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    for (int c = 0; c < 60 && !done; c++) begin
      @(negedge clk_i);
      n_vec++;
      if (w_obs !== exp_vec()) begin
        n_fail++;
        $display("FAIL restart cyc%0d: got %b want %b", c, w_obs, exp_vec());
      end
      if (valid_o && ready_i) outs++;
      if (frame_done_o) fd++;
      tick();
      if (m_state == 0) done = 1;
    end
    n_vec++;
    if (!done || outs != 4 || fd != 1) begin
      n_fail++;
      $display("FAIL restart_totals: got done=%0d outs=%0d done_pulses=%0d want 1 4 1", done, outs, fd);
    end
  endtask

  task automatic test_start_in_active();
    int outs = 0, fd = 0;
    bit done = 0;
    start_i = 1'b1; valid_i = 1'b1; ready_i = 1'b1;
    tick();
    for (int c = 0; c < 60 && !done; c++) begin
      @(negedge clk_i);
      n_vec++;
      if (w_obs !== exp_vec()) begin
        n_fail++;
        $display("FAIL start_in_active cyc%0d: got %b want %b", c, w_obs, exp_vec());
      end
      if (c == 5) begin
        n_vec++;
        if ({col_o, row_o} !== {2'd1, 2'd1}) begin
          n_fail++;
          $display("FAIL start_no_restart: got col=%0d row=%0d want 1 1", col_o, row_o);
        end
      end
      if (valid_o && ready_i) outs++;
      if (frame_done_o) fd++;
      tick();
      if (m_state == 0) begin done = 1; start_i = 1'b0; end
    end
    n_vec++;
    if (!done || outs != 4 || fd != 1) begin
      n_fail++;
      $display("FAIL start_in_active_totals: got done=%0d outs=%0d done_pulses=%0d want 1 4 1", done, outs, fd);
    end
    valid_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_priming();
    test_random();
    test_reset_midframe();
    test_start_in_active();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
